// File: rtl/dadda_cpa_seq_pkg.sv
// Shared types for the Dadda final-adder stage: FSM state encodings and default sizing.
// Also used by the multiplier top-level controller, so the state encodings are fixed.
package dadda_cpa_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DONE = 2'd2
  } cpa_state_t;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_SEG   = 4;

endpackage

// File: rtl/dadda_cpa_seq_if.sv
// Row-in / product-out handshake bundle for the segmented carry-propagate adder.
interface dadda_cpa_seq_if #(
  parameter int WIDTH = dadda_cpa_seq_pkg::DEF_WIDTH
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] row_s;
  logic [WIDTH-1:0] row_c;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] product;
  logic             carry_out;

  // master: the compressor tree / result consumer side
  modport master (
    output in_valid, row_s, row_c, out_ready,
    input  in_ready, out_valid, product, carry_out
  );

  modport slave (
    input  in_valid, row_s, row_c, out_ready,
    output in_ready, out_valid, product, carry_out
  );
endinterface

// File: rtl/dadda_cpa_seq_seg_add.sv
// SEG-bit ripple-carry adder built from full-adder cells; purely combinational.
module dadda_seg_add
  import dadda_cpa_seq_pkg::*;
#(
  parameter int SEG = DEF_SEG
) (
  input  logic [SEG-1:0] i_a,
  input  logic [SEG-1:0] i_b,
  input  logic           i_cin,
  output logic [SEG-1:0] o_s,
  output logic           o_cout
);

  logic [SEG:0] w_c;

  assign w_c[0] = i_cin;

  for (genvar i = 0; i < SEG; i++) begin : g_fa
    assign o_s[i]   = i_a[i] ^ i_b[i] ^ w_c[i];
    assign w_c[i+1] = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
  end

  assign o_cout = w_c[SEG];

endmodule

// File: rtl/dadda_cpa_seq.sv
// Final carry-propagate add of the Dadda sum/carry rows, SEG bits per cycle; result after NSEG edges.
// Accepts only in IDLE; holds product in DONE until out_ready, no accept/issue bypass.
module dadda_cpa_seq
  import dadda_cpa_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SEG   = DEF_SEG
) (
  input  logic           clk,
  input  logic           rst,
  dadda_cpa_seq_if.slave io_bus
);

  localparam int NSEG = WIDTH / SEG;
  localparam int CW   = (NSEG > 1) ? $clog2(NSEG) : 1;
  localparam logic [CW-1:0] LAST_SEG = CW'(NSEG - 1);

  if (WIDTH % SEG != 0) begin : g_bad_seg
    $error("dadda_cpa_seq: SEG must divide WIDTH");
  end

  cpa_state_t       r_state;
  logic [CW-1:0]    r_seg_cnt;
  logic [WIDTH-1:0] r_row_s;
  logic [WIDTH-1:0] r_row_c;
  logic [WIDTH-1:0] r_product;
  logic             r_carry;
  logic             r_carry_out;
  logic             r_in_ready;
  logic             r_out_valid;

  logic [31:0]      w_base;
  logic [SEG-1:0]   w_s_seg;
  logic [SEG-1:0]   w_c_seg;
  logic [SEG-1:0]   w_sum;
  logic             w_cout;

  assign w_base  = 32'(r_seg_cnt) * 32'(SEG);
  assign w_s_seg = r_row_s[w_base +: SEG];
  assign w_c_seg = r_row_c[w_base +: SEG];

  dadda_seg_add #(.SEG(SEG)) u_seg_add (
    .i_a    (w_s_seg),
    .i_b    (w_c_seg),
    .i_cin  (r_carry),
    .o_s    (w_sum),
    .o_cout (w_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_seg_cnt   <= '0;
      r_row_s     <= '0;
      r_row_c     <= '0;
      r_product   <= '0;
      r_carry     <= 1'b0;
      r_carry_out <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (io_bus.in_valid) begin
            r_row_s    <= io_bus.row_s;
            r_row_c    <= io_bus.row_c;
            r_product  <= '0;
            r_carry    <= 1'b0;
            r_seg_cnt  <= '0;
            r_in_ready <= 1'b0;
            r_state    <= ST_ADD;
          end
        end
        ST_ADD: begin
          r_product[w_base +: SEG] <= w_sum;
          r_carry                  <= w_cout;
          r_seg_cnt                <= r_seg_cnt + 1'b1;
          if (r_seg_cnt == LAST_SEG) begin
            r_carry_out <= w_cout;
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (io_bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign io_bus.in_ready  = r_in_ready;
  assign io_bus.out_valid = r_out_valid;
  assign io_bus.product   = r_product;
  assign io_bus.carry_out = r_carry_out;

endmodule

// File: tb/tb_dadda_cpa_seq.sv
// Randomized self-checking bench for dadda_cpa_seq against a plain-arithmetic sum model.
module tb_dadda_cpa_seq;

  localparam int W    = 16;
  localparam int SEG  = 4;
  localparam int NSEG = W / SEG;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  dadda_cpa_seq_if #(.WIDTH(W)) bus ();

  dadda_cpa_seq #(.WIDTH(W), .SEG(SEG)) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // One full transaction; hold>0 keeps out_ready low for that many DONE cycles.
  task automatic run_op(input logic [W-1:0] s, input logic [W-1:0] c,
                        input int hold, input bit mutate);
    logic [W:0] exp;
    int lat;
    exp = {1'b0, s} + {1'b0, c};
    for (int i = 0; i < 20 && !bus.in_ready; i++) begin
      @(posedge clk); #1;
    end
    chk("in_ready_idle", bus.in_ready, 1);
    bus.row_s = s; bus.row_c = c; bus.in_valid = 1'b1;
    bus.out_ready = (hold == 0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    if (mutate) begin
      bus.row_s = 16'($urandom);
      bus.row_c = 16'($urandom);
    end
    chk("in_ready_add", bus.in_ready, 0);
    for (lat = 1; lat <= 20; lat++) begin
      @(posedge clk); #1;
      if (mutate) bus.row_s = ~bus.row_s;
      if (bus.out_valid) break;
    end
    chk("latency", lat, NSEG);
    chk("product", bus.product, exp[W-1:0]);
    chk("carry_out", bus.carry_out, exp[W]);
    for (int h = 0; h < hold; h++) begin
      bus.in_valid = 1'b1;
      bus.row_s = ~s;
      @(posedge clk); #1;
      chk("hold_valid", bus.out_valid, 1);
      chk("hold_in_ready", bus.in_ready, 0);
      chk("hold_product", bus.product, exp[W-1:0]);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("valid_drop", bus.out_valid, 0);
    chk("in_ready_back", bus.in_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] ps[3];
    logic [W-1:0] pc[3];
    logic [W:0]   pe[3];
    int           acc_t[3];
    int           nacc;
    int           nres;
    bit           acc;

    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.row_s = '0; bus.row_c = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_product", bus.product, 0);
    chk("rst_carry_out", bus.carry_out, 0);
    chk("rst_in_ready", bus.in_ready, 1);

    run_op(16'h00FF, 16'h0001, 0, 0);
    run_op(16'hFFFF, 16'h0001, 0, 0);
    run_op(16'h1234, 16'h4321, 3, 0);

    // Reset while the third segment is pending
    bus.row_s = 16'hABCD; bus.row_c = 16'h1111; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_product", bus.product, 0);
    chk("midrst_in_ready", bus.in_ready, 1);
    run_op(16'h0003, 16'h0005, 0, 0);

    run_op(16'($urandom), 16'($urandom), 0, 1);
    for (int i = 0; i < 8; i++)
      run_op(16'($urandom), 16'($urandom), int'($urandom_range(0, 2)), bit'($urandom_range(0, 1)));

    // Back-to-back with in_valid and out_ready held high
    for (int i = 0; i < 3; i++) begin
      ps[i] = 16'($urandom);
      pc[i] = 16'($urandom);
      pe[i] = {1'b0, ps[i]} + {1'b0, pc[i]};
    end
    nacc = 0; nres = 0;
    bus.row_s = ps[0]; bus.row_c = pc[0];
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    for (int cyc = 0; cyc < 60 && nres < 3; cyc++) begin
      acc = bus.in_valid && bus.in_ready;
      if (bus.out_valid) begin
        chk("b2b_product", bus.product, pe[nres][W-1:0]);
        chk("b2b_carry", bus.carry_out, pe[nres][W]);
        nres++;
      end
      @(posedge clk); #1;
      if (acc) begin
        acc_t[nacc] = cyc;
        nacc++;
        if (nacc < 3) begin
          bus.row_s = ps[nacc];
          bus.row_c = pc[nacc];
        end else begin
          bus.in_valid = 1'b0;
        end
      end
    end
    chk("b2b_results", nres, 3);
    chk("b2b_accepts", nacc, 3);
    if (nacc == 3) begin
      chk("b2b_gap0", acc_t[1] - acc_t[0], NSEG + 2);
      chk("b2b_gap1", acc_t[2] - acc_t[1], NSEG + 2);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
